// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a program into instruction RAM, then serves CPU fetches from it
module imem_load_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   output logic                  wr_ready,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] PC,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instr_valid,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] load_count,
   output logic                  load_err
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MAX_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] CAPACITY = ADDR_WIDTH'(MAX_WORDS);
   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  accept;
   logic                  hit;
   // RAM port steering: loader writes in LOAD, in-range fetch reads in RUN (a fetch racing load_start is dropped)
   always_comb begin
      accept    = state == LOAD && wr_valid;
      hit       = state == RUN && fetch_req && !load_start && PC < load_count;
      wr_ready  = state == LOAD;
      stall     = state != RUN;
      mem_cs    = accept || hit;
      mem_we    = accept;
      mem_addr  = accept ? wr_ptr : hit ? PC : '0;
      mem_wdata = accept ? wr_data : '0;
   end
   // Load/run sequencing, overflow detection and the registered fetch result
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         load_count  <= '0;
         load_err    <= 1'b0;
         instruction <= '0;
         instr_valid <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         if (load_start) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            load_err <= 1'b0;
         end else if (accept) begin
            if (wr_last) begin
               load_count <= wr_ptr + ADDR_WIDTH'(1);
               state      <= RUN;
            end else if (wr_ptr == LAST_PTR) begin
               load_err   <= 1'b1;
               load_count <= CAPACITY;
               state      <= RUN;
            end else begin
               wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
         end else if (state == RUN && fetch_req) begin
            instr_valid <= 1'b1;
            instruction <= hit ? mem_rdata : '0;
         end
      end
   end
endmodule
